// File: rtl/main_reg_file.sv
// main_reg_file: 32 x DATA_WIDTH integer register file, x0 hardwired to 0.
// Ports: clk, reset (async, active-low), RegWrite/Rd/Write_data write port,
//        Rs1/Rs2 -> read_data1/read_data2 async reads, dbg_addr -> dbg_data.
module main_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] Rs1,
  input  logic [ADDR_WIDTH-1:0] Rs2,
  input  logic [ADDR_WIDTH-1:0] Rd,
  input  logic [DATA_WIDTH-1:0] Write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] Registers [DEPTH];

  logic wr_en;
  assign wr_en = RegWrite && (Rd != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        Registers[i] <= '0;
      end
    end else if (wr_en) begin
      Registers[Rd] <= Write_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_port(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (reset && (a != '0)) begin
      v = Registers[a];
    end
    return v;
  endfunction

  assign read_data1 = rd_port(Rs1);
  assign read_data2 = rd_port(Rs2);
  assign dbg_data   = rd_port(dbg_addr);

endmodule

// File: tb/tb_main_reg_file.sv
// tb_main_reg_file: directed self-checking bench for main_reg_file.
// Drives on negedge, samples #1 after posedge or mid-cycle.
`timescale 1ns/1ps
module tb_main_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  Rs1, Rs2, Rd, dbg_addr;
  logic [31:0] Write_data;
  logic [31:0] read_data1, read_data2, dbg_data;

  int checks = 0;
  int failures = 0;

  main_reg_file dut (
    .clk        (clk),
    .reset      (reset),
    .RegWrite   (RegWrite),
    .Rs1        (Rs1),
    .Rs2        (Rs2),
    .Rd         (Rd),
    .Write_data (Write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    RegWrite   = 1'b1;
    Rd         = a;
    Write_data = d;
    @(posedge clk);
    #1;
    RegWrite   = 1'b0;
  endtask

  task automatic dbg(input logic [4:0] a, output logic [31:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  logic [31:0] v;

  initial begin
    reset      = 1'b0;
    RegWrite   = 1'b0;
    Rs1        = 5'd0;
    Rs2        = 5'd0;
    Rd         = 5'd0;
    dbg_addr   = 5'd0;
    Write_data = 32'h0;
    #10;
    reset = 1'b1;

    // reset state sweep
    for (int i = 0; i < 32; i++) begin
      dbg(5'(i), v);
      check($sformatf("rst_x%0d", i), v, 32'h0);
    end
    Rs1 = 5'd17;
    Rs2 = 5'd31;
    #1;
    check("rst_rd1", read_data1, 32'h0);
    check("rst_rd2", read_data2, 32'h0);

    // basic write, then hold
    wr(5'd16, 32'hA5A5A5A5);
    Rs1 = 5'd16;
    dbg(5'd16, v);
    check("wr16_dbg", v, 32'hA5A5A5A5);
    check("wr16_rd1", read_data1, 32'hA5A5A5A5);
    repeat (10) @(posedge clk);
    #1;
    check("hold16_dbg", dbg_data, 32'hA5A5A5A5);
    check("hold16_rd1", read_data1, 32'hA5A5A5A5);

    // x0 protection
    wr(5'd0, 32'hFFFFFFFF);
    Rs1 = 5'd0;
    Rs2 = 5'd0;
    #1;
    check("x0_rd1", read_data1, 32'h0);
    check("x0_rd2", read_data2, 32'h0);
    dbg(5'd0, v);
    check("x0_dbg", v, 32'h0);

    // enable gating
    @(negedge clk);
    RegWrite   = 1'b0;
    Rd         = 5'd5;
    Write_data = 32'h12345678;
    repeat (4) @(posedge clk);
    #1;
    dbg(5'd5, v);
    check("gate_x5", v, 32'h0);

    // dual read
    wr(5'd3, 32'h11111111);
    wr(5'd4, 32'h22222222);
    Rs1 = 5'd3;
    Rs2 = 5'd4;
    #1;
    check("dual_rd1", read_data1, 32'h11111111);
    check("dual_rd2", read_data2, 32'h22222222);
    Rs2 = 5'd3;
    #1;
    check("same_rd2", read_data2, 32'h11111111);

    // same-cycle write/read: no bypass
    @(negedge clk);
    RegWrite   = 1'b1;
    Rd         = 5'd3;
    Write_data = 32'hDEADBEEF;
    #1;
    check("haz_before", read_data1, 32'h11111111);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    check("haz_after", read_data1, 32'hDEADBEEF);

    // fill x1..x31 with index
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i));
    end
    dbg(5'd31, v);
    check("fill_x31", v, 32'd31);
    dbg(5'd7, v);
    check("fill_x7", v, 32'd7);

    // async reset between edges, with a pending write
    @(negedge clk);
    RegWrite   = 1'b1;
    Rd         = 5'd9;
    Write_data = 32'hCAFEF00D;
    Rs1        = 5'd7;
    Rs2        = 5'd31;
    dbg_addr   = 5'd16;
    #2;
    reset = 1'b0;
    #1;
    check("arst_rd1", read_data1, 32'h0);
    check("arst_rd2", read_data2, 32'h0);
    check("arst_dbg", dbg_data, 32'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      dbg(5'(i), v);
      check($sformatf("post_arst_x%0d", i), v, 32'h0);
    end

    // write works again after release
    wr(5'd9, 32'h0BADF00D);
    dbg(5'd9, v);
    check("rel_x9", v, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_reg_file.md
Name: main_reg_file

Overview:
- Integer register file for the single-cycle RISC-V core: 32 x 32-bit registers (x0..x31).
- Two combinational read ports serve the decode stage; one synchronous write port serves write-back.
- A debug read port gives benches and the top level visibility of any register, with no hierarchical access.
- x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH = 32.

Ports:
- clk  input  1  system clock; writes on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all registers.
- RegWrite  input  1  write enable for the write port.
- Rs1  input  ADDR_WIDTH  read port 1 register index.
- Rs2  input  ADDR_WIDTH  read port 2 register index.
- Rd  input  ADDR_WIDTH  write destination register index.
- Write_data  input  DATA_WIDTH  data written to Rd.
- read_data1  output  DATA_WIDTH  contents of register Rs1.
- read_data2  output  DATA_WIDTH  contents of register Rs2.
- dbg_addr  input  ADDR_WIDTH  debug read index.
- dbg_data  output  DATA_WIDTH  contents of register dbg_addr.

Behaviour:
- Storage: array Registers[0..31], each DATA_WIDTH bits.
- Reset:
  - reset=0 clears every register to 32'h0 immediately, independent of clk.
  - While reset=0, writes are blocked and all read outputs show 0.
  - Registers hold 0 after reset deasserts until written.
- Write:
  - On rising clk edge with reset=1, RegWrite=1 and Rd!=0: Registers[Rd] <= Write_data.
  - RegWrite=0: no register changes.
  - Rd=0: the write is silently discarded; x0 always reads 0.
- Read:
  - Purely combinational, zero latency: read_data1 = (Rs1==0) ? 0 : Registers[Rs1].
  - read_data2 and dbg_data follow the same rule with Rs2 and dbg_addr.
  - Outputs track address changes within the same cycle.
- Write/read same index in the same cycle:
  - No internal bypass. The read returns the old value until the clock edge and the new value after it.
  - Forwarding is omitted on purpose: it would form a combinational loop in the single-cycle datapath.
- Both read ports may address the same register simultaneously; both return the same value.
- Reset asserted mid-cycle during a pending write: reset wins and the register ends at 0.
- Reset released coincident with a rising edge: the write on that edge is not required to take effect. Benches must deassert reset at least one half-cycle before the first write.
- No X propagation from unwritten registers; all reset to 0.

Test Plan:
- Reset: drive reset=0 for 10 ns, then 1. Sweep dbg_addr 0..31 -> dbg_data=0 for every index; read_data1/read_data2=0.
- Basic write: RegWrite=1, Rd=16, Write_data=32'hA5A5A5A5 for one edge, then RegWrite=0. Result: dbg_addr=16 and Rs1=16 read A5A5A5A5 and keep that value for 100 ns of further clocks.
- x0 protection: RegWrite=1, Rd=0, Write_data=32'hFFFFFFFF. Rs1=0 and Rs2=0 -> read 0.
- Enable gating: RegWrite=0, Rd=5, Write_data=32'h12345678 over several edges -> register 5 stays 0.
- Dual read and same-cycle hazard:
  - Write x3=32'h11111111 and x4=32'h22222222; Rs1=3, Rs2=4 -> 11111111 / 22222222.
  - Next, RegWrite=1, Rd=3, Write_data=32'hDEADBEEF with Rs1=3 -> reads 11111111 before the edge and DEADBEEF after it.
- Async reset mid-operation: fill x1..x31 with the index value. Pulse reset=0 between clock edges -> all registers read 0 at once, without waiting for a clk edge.
